// File: rtl/ex_muldiv.sv
// RV32M multiply/divide execution unit: iterative shift-add multiplier and restoring divider.
// Optional MULDIV_FAST_MUL_EN selects a single-cycle multiplier; division is always iterative.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             kill_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_func3_i,
  input  logic [XLEN-1:0]  req_op1_i,
  input  logic [XLEN-1:0]  req_op2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_result_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    cneg = n ? (~v + ONE) : v;
  endfunction

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q, hi_q, lo_q;
  logic              neg_q, rneg_q;
  logic              ready_q, valid_q, busy_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;

  logic              op1_signed_s, op2_signed_s, op1_neg_s, op2_neg_s;
  logic [XLEN-1:0]   op1_mag_s, op2_mag_s, spec_res_s, fin_s;
  logic              is_div_s, div_zero_s, div_ovf_s;
  logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [XLEN-1:0]   step_hi_s, step_lo_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  // Operand signedness from funct3: MULH/DIV/REM signed both, MULHSU signed rs1 only.
  always_comb begin
    op1_signed_s = 1'b0;
    op2_signed_s = 1'b0;
    case (req_func3_i)
      3'b001, 3'b100, 3'b110: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
      end
      3'b010: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b0;
      end
      default: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
      end
    endcase
  end

  assign op1_neg_s  = op1_signed_s & req_op1_i[XLEN-1];
  assign op2_neg_s  = op2_signed_s & req_op2_i[XLEN-1];
  assign op1_mag_s  = cneg(req_op1_i, op1_neg_s);
  assign op2_mag_s  = cneg(req_op2_i, op2_neg_s);
  assign is_div_s   = req_func3_i[2];
  assign div_zero_s = (req_op2_i == {XLEN{1'b0}});
  assign div_ovf_s  = ~req_func3_i[0] & (req_op1_i == MIN_NEG) & (req_op2_i == ALL_ONE);

  // Early-out results: divide by zero and signed overflow never enter the iteration.
  always_comb begin
    spec_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      spec_res_s = req_func3_i[1] ? req_op1_i : ALL_ONE;
    end else begin
      spec_res_s = req_func3_i[1] ? {XLEN{1'b0}} : req_op1_i;
    end
  end

  // One iteration: hi/lo hold partial product or remainder/quotient, a_q the multiplicand/divisor.
  assign mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign div_sh_s   = {hi_q, lo_q[XLEN-1]};
  assign div_diff_s = div_sh_s - {1'b0, a_q};

  always_comb begin
    step_hi_s = mul_sum_s[XLEN:1];
    step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
    if (f3_q[2]) begin
      step_hi_s = div_diff_s[XLEN] ? div_sh_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
      step_lo_s = {lo_q[XLEN-2:0], ~div_diff_s[XLEN]};
    end else begin
      step_hi_s = mul_sum_s[XLEN:1];
      step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod_s     = {step_hi_s, step_lo_s};
  assign prod_fix_s = neg_q ? (~prod_s + (2*XLEN)'(1)) : prod_s;

  always_comb begin
    fin_s = {XLEN{1'b0}};
    if (f3_q[2]) begin
      fin_s = f3_q[1] ? cneg(step_hi_s, rneg_q) : cneg(step_lo_s, neg_q);
    end else if (f3_q[1:0] == 2'b00) begin
      fin_s = prod_fix_s[XLEN-1:0];
    end else begin
      fin_s = prod_fix_s[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa_s, fb_s, fp_s;
  logic [XLEN-1:0]   fast_res_s;
  assign fa_s       = {{XLEN{op1_neg_s}}, req_op1_i};
  assign fb_s       = {{XLEN{op2_neg_s}}, req_op2_i};
  assign fp_s       = fa_s * fb_s;
  assign fast_res_s = (req_func3_i[1:0] == 2'b00) ? fp_s[XLEN-1:0] : fp_s[2*XLEN-1:XLEN];
`endif

  // Control FSM and datapath registers; kill_i overrides every state.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      f3_q     <= 3'b000;
      a_q      <= {XLEN{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
      tag_q    <= {TAG_W{1'b0}};
    end else if (kill_i) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            f3_q    <= req_func3_i;
            tag_q   <= req_tag_i;
            hi_q    <= {XLEN{1'b0}};
            neg_q   <= op1_neg_s ^ op2_neg_s;
            rneg_q  <= op1_neg_s;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (is_div_s) begin
              a_q  <= op2_mag_s;
              lo_q <= op1_mag_s;
            end else begin
              a_q  <= op1_mag_s;
              lo_q <= op2_mag_s;
            end
            if (is_div_s && (div_zero_s || div_ovf_s)) begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= spec_res_s;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div_s) begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= fast_res_s;
`endif
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(XLEN-1);
            end
          end
        end
        S_BUSY: begin
          hi_q <= step_hi_s;
          lo_q <= step_lo_s;
          if (cnt_q == {CW{1'b0}}) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= fin_s;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o   = ready_q;
  assign resp_valid_o  = valid_q;
  assign resp_result_o = result_q;
  assign resp_tag_o    = tag_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (XLEN=32): directed vectors, corner sequences, random vs. arithmetic model.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst_i, kill_i, req_valid_i, req_ready_o, resp_valid_o, resp_ready_i, busy_o;
  logic [2:0]  req_func3_i;
  logic [31:0] req_op1_i, req_op2_i, resp_result_o;
  logic [4:0]  req_tag_i, resp_tag_o;

  int checks = 0;
  int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  ex_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_i(rst_i), .kill_i(kill_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_func3_i(req_func3_i),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tg;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, sp;
    logic [63:0] ua, ubv, up;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ua  = {32'd0, a};
    ubv = {32'd0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin up = ua * ubv; ref_res = up[31:0]; end
      3'd1: begin sp = sa * sb; ref_res = sp[63:32]; end
      3'd2: begin sp = sa * ub; ref_res = sp[63:32]; end
      3'd3: begin up = ua * ubv; ref_res = up[63:32]; end
      3'd4: ref_res = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: ref_res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_res = (b == 32'd0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: ref_res = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, scramble inputs after acceptance, measure latency, check result/tag, consume.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    chk({nm, ".req_ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_func3_i = f3; req_op1_i = a; req_op2_i = b; req_tag_i = tg;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_func3_i = 3'($urandom); req_op1_i = $urandom; req_op2_i = $urandom; req_tag_i = 5'($urandom);
    n = 1;
    @(negedge clk);
    while (!resp_valid_o && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, ".latency"}, 32'(n), 32'(exp_lat));
    chk({nm, ".result"}, resp_result_o, exp_res);
    chk({nm, ".tag"}, {27'd0, resp_tag_o}, {27'd0, tg});
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_after"}, {30'd0, req_ready_o, resp_valid_o}, 32'd2);
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    @(negedge clk);
    req_valid_i = 1'b1; req_func3_i = f3; req_op1_i = a; req_op2_i = b; req_tag_i = tg;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic expect_silence(input string nm);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid_o) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          sel, n;

    vecs[0]  = '{3'd5, 32'd100,        32'd7,          5'd9,  32'd14,         33};
    vecs[1]  = '{3'd7, 32'd100,        32'd7,          5'd1,  32'd2,          33};
    vecs[2]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd2,  32'h8000_0000,  1};
    vecs[3]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  32'd0,          1};
    vecs[4]  = '{3'd5, 32'hDEAD_BEEF,  32'd0,          5'd4,  32'hFFFF_FFFF,  1};
    vecs[5]  = '{3'd6, 32'h0000_1234,  32'd0,          5'd5,  32'h0000_1234,  1};
    vecs[6]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000,  MUL_LAT};
    vecs[7]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE,  MUL_LAT};
    vecs[8]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF,  MUL_LAT};
    vecs[9]  = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'd1,          MUL_LAT};
    vecs[10] = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFD,  33};
    vecs[11] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd12, 32'hFFFF_FFFF,  33};

    rst_i = 1'b1; kill_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
    req_func3_i = 3'd0; req_op1_i = 32'd0; req_op2_i = 32'd0; req_tag_i = 5'd0;
    #12;
    chk("reset.ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset.valid_busy", {30'd0, resp_valid_o, busy_o}, 32'd0);
    chk("reset.result", resp_result_o, 32'd0);
    chk("reset.tag", {27'd0, resp_tag_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tg, vecs[i].res, vecs[i].lat);
    end

    // Kill during BUSY, then a clean DIVU 9/3.
    start_op(3'd5, 32'd1000, 32'd3, 5'd13);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("kill.busy_before", {31'd0, busy_o}, 32'd1);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill.state_after", {29'd0, req_ready_o, resp_valid_o, busy_o}, 32'd4);
    expect_silence("kill.no_result");
    run_op("kill.divu9_3", 3'd5, 32'd9, 32'd3, 5'd14, 32'd3, 33);

    // Consumer stall in DONE; a request offered meanwhile must not be taken.
    start_op(3'd7, 32'd100, 32'd7, 5'd3);
    n = 1;
    @(negedge clk);
    while (!resp_valid_o && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("stall.latency", 32'(n), 32'd33);
    req_valid_i = 1'b1; req_func3_i = 3'd5; req_op1_i = 32'd9; req_op2_i = 32'd3; req_tag_i = 5'd20;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall.result%0d", i), resp_result_o, 32'd2);
      chk($sformatf("stall.tag%0d", i), {27'd0, resp_tag_o}, 32'd3);
      chk($sformatf("stall.hs%0d", i), {30'd0, resp_valid_o, req_ready_o}, 32'd2);
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    chk("stall.ready_low_at_release", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    @(negedge clk);
    chk("stall.idle_after", {29'd0, req_ready_o, resp_valid_o, busy_o}, 32'd4);

    // Asynchronous reset in the middle of BUSY.
    start_op(3'd4, 32'd12345, 32'd67, 5'd21);
    repeat (5) @(posedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("arst.valid_busy", {30'd0, resp_valid_o, busy_o}, 32'd0);
    chk("arst.result", resp_result_o, 32'd0);
    chk("arst.tag", {27'd0, resp_tag_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    expect_silence("arst.no_result");
    run_op("arst.after", 3'd4, 32'd12345, 32'd67, 5'd22, ref_res(3'd4, 32'd12345, 32'd67), 33);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = -a;
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, 5'($urandom), ref_res(f3, a, b), ref_lat(f3, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
